// File: rtl/dp_ram.sv
// True dual-port synchronous RAM with a post-reset clear sequencer, selectable
// same-port read-during-write behaviour, optional output register and collision flag.
module dp_ram #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int MODE    = 0,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_a,
  input  logic             we_a,
  input  logic [ADDR-1:0]  addr_a,
  input  logic [WIDTH-1:0] din_a,
  output logic [WIDTH-1:0] dout_a,
  output logic             valid_a,
  input  logic             en_b,
  input  logic             we_b,
  input  logic [ADDR-1:0]  addr_b,
  input  logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout_b,
  output logic             valid_b,
  output logic             busy,
  output logic             collision
);

  localparam int DEPTH = 1 << ADDR;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state;
  logic [ADDR:0]    clr_cnt;
  logic [ADDR:0]    clr_next;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             acc_a, acc_b;
  logic [WIDTH-1:0] d1_a, d1_b;
  logic             v1_a, v1_b, c1;

  // Extra counter bit flags the end of the sweep without wrapping back to 0.
  assign clr_next = clr_cnt + (ADDR+1)'(1);
  assign busy     = (state == S_CLEAR);
  assign acc_a    = (state == S_RUN) && en_a;
  assign acc_b    = (state == S_RUN) && en_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_next;
      if (clr_next[ADDR]) state <= S_RUN;
    end
  end

  // Port A is written after port B so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt[ADDR-1:0]] <= '0;
      end else begin
        if (acc_b && we_b) mem[addr_b] <= din_b;
        if (acc_a && we_a) mem[addr_a] <= din_a;
      end
    end
  end

  // Array reads see pre-write contents, so a reading port always gets old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_a <= '0;
      d1_b <= '0;
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      c1   <= 1'b0;
    end else begin
      v1_a <= acc_a && !(we_a && MODE == 2);
      v1_b <= acc_b && !(we_b && MODE == 2);
      c1   <= acc_a && acc_b && (addr_a == addr_b) && (we_a || we_b);
      if (acc_a) begin
        if (!we_a || MODE == 0) d1_a <= mem[addr_a];
        else if (MODE == 1)     d1_a <= din_a;
      end
      if (acc_b) begin
        if (!we_b || MODE == 0) d1_b <= mem[addr_b];
        else if (MODE == 1)     d1_b <= din_b;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] d2_a, d2_b;
      logic             v2_a, v2_b, c2;

      always_ff @(posedge clk) begin
        if (rst) begin
          d2_a <= '0;
          d2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
          c2   <= 1'b0;
        end else begin
          d2_a <= d1_a;
          d2_b <= d1_b;
          v2_a <= v1_a;
          v2_b <= v1_b;
          c2   <= c1;
        end
      end

      assign dout_a    = d2_a;
      assign dout_b    = d2_b;
      assign valid_a   = v2_a;
      assign valid_b   = v2_b;
      assign collision = c2;
    end else begin : g_no_out_reg
      assign dout_a    = d1_a;
      assign dout_b    = d1_b;
      assign valid_a   = v1_a;
      assign valid_b   = v1_b;
      assign collision = c1;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram.sv
// Directed bench for dp_ram: four configurations share one stimulus stream
// (MODE 0/1/2 with latency 1, and MODE 0 with the output register, latency 2).
module tb_dp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en_a, we_a, en_b, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;
  logic [7:0] dout_a [4];
  logic [7:0] dout_b [4];
  logic       valid_a [4];
  logic       valid_b [4];
  logic       busy [4];
  logic       coll [4];

  int total  = 0;
  int passed = 0;

  dp_ram #(.WIDTH(8), .ADDR(4), .MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[0]), .valid_a(valid_a[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[0]), .valid_b(valid_b[0]),
    .busy(busy[0]), .collision(coll[0]));
  dp_ram #(.WIDTH(8), .ADDR(4), .MODE(1), .OUT_REG(0)) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[1]), .valid_a(valid_a[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[1]), .valid_b(valid_b[1]),
    .busy(busy[1]), .collision(coll[1]));
  dp_ram #(.WIDTH(8), .ADDR(4), .MODE(2), .OUT_REG(0)) u2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[2]), .valid_a(valid_a[2]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[2]), .valid_b(valid_b[2]),
    .busy(busy[2]), .collision(coll[2]));
  dp_ram #(.WIDTH(8), .ADDR(4), .MODE(0), .OUT_REG(1)) u3 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[3]), .valid_a(valid_a[3]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[3]), .valid_b(valid_b[3]),
    .busy(busy[3]), .collision(coll[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic set_a(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    en_a = en; we_a = we; addr_a = ad; din_a = d;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    en_b = en; we_b = we; addr_b = ad; din_b = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle(); addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({dout_a[i], dout_b[i], valid_a[i], valid_b[i], coll[i], busy[i]} !== {8'h00, 8'h00, 4'b0001})
        $display("FAIL reset inst%0d dout_a=%h dout_b=%h va=%b vb=%b coll=%b busy=%b exp 00 00 0 0 0 1",
                 i, dout_a[i], dout_b[i], valid_a[i], valid_b[i], coll[i], busy[i]);
      else passed++;
    end
  endtask

  task automatic test_clear;
    int n = 0;
    rst = 1'b0;
    do begin
      if (n == 10) set_a(1'b1, 1'b1, 4'h3, 8'hFF);
      else if (n == 12) idle();
      tick();
      n++;
      if (n == 11 || n == 12) begin
        for (int i = 0; i < 4; i++) begin
          total++;
          if (valid_a[i] !== 1'b0) $display("FAIL busy_valid inst%0d valid_a=%b exp 0", i, valid_a[i]);
          else passed++;
        end
      end
    end while (busy[0] === 1'b1 && n < 40);
    total++;
    if (n !== 16) $display("FAIL clear_cycles got %0d exp 16", n);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy[i] !== 1'b0) $display("FAIL busy_done inst%0d busy=%b exp 0", i, busy[i]);
      else passed++;
    end
  endtask

  task automatic test_clear_readback;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) set_a(1'b1, 1'b0, 4'(k), 8'h00); else idle();
      tick();
      if (k < 16)
        for (int i = 0; i < 3; i++) begin
          total++;
          if ({valid_a[i], dout_a[i]} !== {1'b1, 8'h00})
            $display("FAIL clear_rd addr%0d inst%0d valid=%b dout=%h exp 1 00", k, i, valid_a[i], dout_a[i]);
          else passed++;
        end
      if (k >= 1) begin
        total++;
        if ({valid_a[3], dout_a[3]} !== {1'b1, 8'h00})
          $display("FAIL clear_rd addr%0d inst3 valid=%b dout=%h exp 1 00", k - 1, valid_a[3], dout_a[3]);
        else passed++;
      end
    end
  endtask

  task automatic test_write_readback;
    for (int k = 0; k < 6; k++) begin
      set_a(1'b1, 1'b1, 4'(8 - k), 8'(k + 1));
      tick();
    end
    idle();
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) set_b(1'b1, 1'b0, 4'(8 - k), 8'h00); else idle();
      tick();
      if (k < 6)
        for (int i = 0; i < 3; i++) begin
          total++;
          if ({valid_b[i], dout_b[i]} !== {1'b1, 8'(k + 1)})
            $display("FAIL wr_rd k%0d inst%0d valid_b=%b dout_b=%h exp 1 %h", k, i, valid_b[i], dout_b[i], 8'(k + 1));
          else passed++;
        end
      if (k >= 1) begin
        total++;
        if ({valid_b[3], dout_b[3]} !== {1'b1, 8'(k)})
          $display("FAIL wr_rd k%0d inst3 valid_b=%b dout_b=%h exp 1 %h", k - 1, valid_b[3], dout_b[3], 8'(k));
        else passed++;
      end
    end
  endtask

  task automatic test_rdw;
    set_a(1'b1, 1'b0, 4'h8, 8'h00);
    tick();
    set_a(1'b1, 1'b1, 4'h5, 8'hAA);
    tick();
    total++;
    if ({valid_a[0], dout_a[0]} !== {1'b1, 8'h04}) $display("FAIL rdw_mode0 valid=%b dout=%h exp 1 04", valid_a[0], dout_a[0]);
    else passed++;
    total++;
    if ({valid_a[1], dout_a[1]} !== {1'b1, 8'hAA}) $display("FAIL rdw_mode1 valid=%b dout=%h exp 1 aa", valid_a[1], dout_a[1]);
    else passed++;
    total++;
    if ({valid_a[2], dout_a[2]} !== {1'b0, 8'h01}) $display("FAIL rdw_mode2 valid=%b dout=%h exp 0 01", valid_a[2], dout_a[2]);
    else passed++;
    total++;
    if ({valid_a[3], dout_a[3]} !== {1'b1, 8'h01}) $display("FAIL rdw_lat2_prev valid=%b dout=%h exp 1 01", valid_a[3], dout_a[3]);
    else passed++;
    idle();
    tick();
    total++;
    if ({valid_a[3], dout_a[3]} !== {1'b1, 8'h04}) $display("FAIL rdw_lat2 valid=%b dout=%h exp 1 04", valid_a[3], dout_a[3]);
    else passed++;
    set_a(1'b1, 1'b0, 4'h5, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({valid_a[i], dout_a[i]} !== {1'b1, 8'hAA}) $display("FAIL rdw_after inst%0d valid=%b dout=%h exp 1 aa", i, valid_a[i], dout_a[i]);
      else passed++;
    end
    idle();
    tick();
    total++;
    if ({valid_a[3], dout_a[3]} !== {1'b1, 8'hAA}) $display("FAIL rdw_after inst3 valid=%b dout=%h exp 1 aa", valid_a[3], dout_a[3]);
    else passed++;
  endtask

  task automatic test_collision;
    set_a(1'b1, 1'b1, 4'h7, 8'h11);
    set_b(1'b1, 1'b1, 4'h7, 8'h22);
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (coll[i] !== (i < 3)) $display("FAIL coll_ww inst%0d coll=%b exp %b", i, coll[i], (i < 3));
      else passed++;
    end
    idle();
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (coll[i] !== (i == 3)) $display("FAIL coll_pulse inst%0d coll=%b exp %b", i, coll[i], (i == 3));
      else passed++;
    end
    tick();
    total++;
    if (coll[3] !== 1'b0) $display("FAIL coll_pulse_end inst3 coll=%b exp 0", coll[3]);
    else passed++;
    set_a(1'b1, 1'b0, 4'h7, 8'h00);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout_a[i] !== 8'h11) $display("FAIL coll_ww_data inst%0d dout_a=%h exp 11", i, dout_a[i]);
      else passed++;
    end
    tick();
    total++;
    if (dout_a[3] !== 8'h11) $display("FAIL coll_ww_data inst3 dout_a=%h exp 11", dout_a[3]);
    else passed++;
    set_a(1'b1, 1'b1, 4'h7, 8'h33);
    set_b(1'b1, 1'b0, 4'h7, 8'h00);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({coll[i], valid_b[i], dout_b[i]} !== {2'b11, 8'h11})
        $display("FAIL coll_wr inst%0d coll=%b valid_b=%b dout_b=%h exp 1 1 11", i, coll[i], valid_b[i], dout_b[i]);
      else passed++;
    end
    tick();
    total++;
    if ({coll[3], valid_b[3], dout_b[3]} !== {2'b11, 8'h11})
      $display("FAIL coll_wr inst3 coll=%b valid_b=%b dout_b=%h exp 1 1 11", coll[3], valid_b[3], dout_b[3]);
    else passed++;
    set_a(1'b1, 1'b0, 4'h7, 8'h00);
    set_b(1'b1, 1'b0, 4'h7, 8'h00);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({coll[i], dout_a[i], dout_b[i]} !== {1'b0, 8'h33, 8'h33})
        $display("FAIL coll_rr inst%0d coll=%b dout_a=%h dout_b=%h exp 0 33 33", i, coll[i], dout_a[i], dout_b[i]);
      else passed++;
    end
    tick();
    total++;
    if ({coll[3], dout_a[3], dout_b[3]} !== {1'b0, 8'h33, 8'h33})
      $display("FAIL coll_rr inst3 coll=%b dout_a=%h dout_b=%h exp 0 33 33", coll[3], dout_a[3], dout_b[3]);
    else passed++;
  endtask

  task automatic test_idle_hold;
    set_a(1'b1, 1'b1, 4'h2, 8'h42);
    tick();
    set_a(1'b1, 1'b0, 4'h2, 8'h00);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({valid_a[i], dout_a[i]} !== {1'b1, 8'h42}) $display("FAIL hold_rd inst%0d valid=%b dout=%h exp 1 42", i, valid_a[i], dout_a[i]);
      else passed++;
    end
    tick();
    total++;
    if ({valid_a[3], dout_a[3]} !== {1'b1, 8'h42}) $display("FAIL hold_rd inst3 valid=%b dout=%h exp 1 42", valid_a[3], dout_a[3]);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({valid_a[i], dout_a[i]} !== {1'b0, 8'h42})
          $display("FAIL hold_idle c%0d inst%0d valid=%b dout=%h exp 0 42", c, i, valid_a[i], dout_a[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] addrs [3];
    int n = 0;
    addrs[0] = 4'h8; addrs[1] = 4'h7; addrs[2] = 4'h2;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({dout_a[i], valid_a[i], dout_b[i], valid_b[i], busy[i]} !== {8'h00, 1'b0, 8'h00, 2'b01})
        $display("FAIL rst_run inst%0d dout_a=%h va=%b dout_b=%h vb=%b busy=%b exp 00 0 00 0 1",
                 i, dout_a[i], valid_a[i], dout_b[i], valid_b[i], busy[i]);
      else passed++;
    end
    rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do begin
      tick();
      n++;
    end while (busy[0] === 1'b1 && n < 40);
    total++;
    if (n !== 16) $display("FAIL restart_cycles got %0d exp 16", n);
    else passed++;
    for (int k = 0; k <= 3; k++) begin
      if (k < 3) set_a(1'b1, 1'b0, addrs[k], 8'h00); else idle();
      tick();
      if (k < 3)
        for (int i = 0; i < 3; i++) begin
          total++;
          if ({valid_a[i], dout_a[i]} !== {1'b1, 8'h00})
            $display("FAIL rezero k%0d inst%0d valid=%b dout=%h exp 1 00", k, i, valid_a[i], dout_a[i]);
          else passed++;
        end
      if (k >= 1) begin
        total++;
        if ({valid_a[3], dout_a[3]} !== {1'b1, 8'h00})
          $display("FAIL rezero k%0d inst3 valid=%b dout=%h exp 1 00", k - 1, valid_a[3], dout_a[3]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_clear_readback();
    test_write_readback();
    test_rdw();
    test_collision();
    test_idle_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dp_ram.md
# dp_ram

Parametrised true dual-port synchronous RAM, the successor to the single-port `sp_ram`. It adds:
- two independent read/write ports sharing one clock;
- a selectable read-during-write mode;
- an optional output pipeline register with per-port valid flags;
- a reset-driven clear sequencer that zeroes the whole array;
- collision detection.

It is the general storage primitive for buffers and register files in the design.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- ADDR, 4, address width; depth = 2^ADDR words
- MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data), 2 = no-change (dout holds)
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2

- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, synchronous active-high reset
- en_a, in, 1, port A access enable
- we_a, in, 1, port A write enable (ignored when en_a=0)
- addr_a, in, ADDR, port A address
- din_a, in, WIDTH, port A write data
- dout_a, out, WIDTH, port A read data
- valid_a, out, 1, dout_a updated this cycle
- en_b, we_b, addr_b, din_b, dout_b, valid_b: port B, identical to port A
- busy, out, 1, clear sequence in progress; all port accesses ignored
- collision, out, 1, one-cycle pulse: both ports accessed the same address and at least one was writing

## Operation
- Reset:
  - While rst=1: dout_a/b=0, valid_a/b=0, collision=0, busy=1, clear counter=0.
  - Pipeline stages are cleared as well.
- State machine:
  - CLEAR: on each cycle after rst deasserts, write 0 to mem[counter] and increment the counter. After address 2^ADDR−1 is written, move to RUN. busy=1 throughout CLEAR.
  - RUN: busy=0. Stays in RUN until the next rst.
  - rst asserted mid-clear restarts CLEAR from address 0.
- Port access in RUN, per port, when en=1:
  - we=1: mem[addr] ← din.
  - dout and valid depend on MODE:
    - MODE 0: dout ← old mem[addr], valid=1.
    - MODE 1: dout ← din, valid=1.
    - MODE 2: dout unchanged, valid=0.
  - we=0: dout ← mem[addr], valid=1 (all modes).
- en=0 or busy=1: no write; dout holds its last value; valid=0.
- Cross-port rules in RUN, when both ports are enabled and addr_a==addr_b:
  - Both writing: port A's data is stored; collision=1.
  - One writing, one reading: the reading port returns the old data, independent of MODE; the write completes; collision=1.
  - Both reading: both return the same data; collision=0.
- collision is registered and pulses on the cycle after the colliding access.
- Address arithmetic: the clear counter is ADDR+1 bits so termination is detected without wrap. Port addresses need no range check because the array covers all 2^ADDR words.

## Timing
- OUT_REG=0: access sampled at edge N; dout/valid present after edge N (latency 1). collision is aligned with valid.
- OUT_REG=1: dout/valid present after edge N+1 (latency 2). collision is delayed by the same stage so it stays aligned with valid.
- Back-to-back accesses at full rate on both ports; no wait states in RUN.
- valid is a one-cycle qualifier per access; continuous enables give continuous valid.
- busy timing:
  - busy falls after the edge that writes the last word, i.e. 2^ADDR cycles after rst deasserts (16 for ADDR=4).
  - The first access on the cycle busy=0 is accepted.
- Write data becomes visible to a read on the following cycle at either port.

## Test plan
- Reset/clear: pulse rst, count cycles until busy=0 → exactly 16 (ADDR=4). Then read all addresses on port A → every dout=0x00, valid=1. During busy, issue en_a=1 we_a=1 addr=0x3 din=0xFF → ignored; a later read of 0x3 returns 0x00.
- Write/readback: port A writes 0x01..0x06 to addresses 0x8..0x3, then port B reads 0x8..0x3 → 0x01..0x06, each with valid_b, latency 1 (OUT_REG=0) and latency 2 (OUT_REG=1).
- Read-during-write: with mem[0x5]=0x04, port A writes 0xAA to 0x5. Required dout_a: MODE 0 → 0x04, valid=1; MODE 1 → 0xAA, valid=1; MODE 2 → dout unchanged, valid=0. A subsequent read in every mode → 0xAA.
- Collision: same cycle, A writes 0x11 and B writes 0x22 to 0x7 → collision pulses once; a read of 0x7 → 0x11. Then A writes 0x33 to 0x7 while B reads 0x7 → dout_b=0x11, collision=1, and a later read → 0x33.
- Reset mid-operation: assert rst while busy with the counter at 0x9 → busy remains high for 16 further cycles after the release. Assert rst in RUN after writes → dout/valid=0 immediately and memory re-zeroed.
- Idle hold: drop en_a after a read of 0x42 → dout_a holds 0x42 and valid_a=0 for all following idle cycles.
